pool_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for the max-pool stage. It accepts one feature-map pixel per handshake in raster order and buffers the two previous rows in line buffers. For every pooling position at the configured stride, it emits the nine window pixels packed into one neighbourhood vector, ready for the pooling unit. The block does not interpret pixel values; data is opaque NN_WIDTH words.

---
 rtl/pool_window_gen_pkg.sv | 25 ++
 rtl/pool_window_gen_line_buffer.sv | 31 +++
 rtl/pool_window_gen.sv | 164 ++++++++++++++++
 tb/tb_pool_window_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_gen_pkg.sv
// ============================================================================
// pool_window_gen_pkg : shared constants and types for the pool window path
// Revision: 1.0
// ============================================================================
`default_nettype none

package pool_window_gen_pkg;

   localparam int NN_WIDTH        = 32;
   localparam int NH_VECTOR_WIDTH = 9 * NN_WIDTH;

   typedef enum logic [1:0] {
      PH_FILL = 2'd0,
      PH_EMIT = 2'd1,
      PH_SKIP = 2'd2
   } row_phase_t;

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pool_window_gen_line_buffer.sv
// ============================================================================
// pool_line_buffer : DEPTH x WIDTH word store, asynchronous read, write on enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module pool_line_buffer #(
   parameter int DEPTH = 13,
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/pool_window_gen.sv
// ============================================================================
// pool_window_gen : streaming 3x3 neighbourhood generator for max-pool
// Revision: 1.0
// ============================================================================
`default_nettype none

module pool_window_gen
   import pool_window_gen_pkg::*;
#(
   parameter int MAP_W  = 13,
   parameter int MAP_H  = 13,
   parameter int STRIDE = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [NN_WIDTH-1:0]        s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [NH_VECTOR_WIDTH-1:0] m_data,
   output logic                       m_last
);

   localparam int CW = cnt_width(MAP_W);
   localparam int RW = cnt_width(MAP_H);
   localparam int SW = cnt_width(STRIDE);

   localparam logic [CW-1:0] c_col_max  = CW'(MAP_W - 1);
   localparam logic [RW-1:0] c_row_max  = RW'(MAP_H - 1);
   localparam logic [CW-1:0] c_last_col = CW'(2 + ((MAP_W - 3) / STRIDE) * STRIDE);
   localparam logic [RW-1:0] c_last_row = RW'(2 + ((MAP_H - 3) / STRIDE) * STRIDE);
   localparam logic [SW-1:0] c_step_max = SW'(STRIDE - 1);

   logic [CW-1:0]       r_col;
   logic [RW-1:0]       r_row;
   logic [SW-1:0]       r_cstep;
   logic [SW-1:0]       r_rstep;
   row_phase_t          r_phase;

   logic                w_accept;
   logic                w_col_end;
   logic                w_row_end;
   logic                w_col_aligned;
   logic                w_emit;
   logic                w_last;
   logic [SW-1:0]       w_rstep_next;
   logic [NN_WIDTH-1:0] w_lb0;
   logic [NN_WIDTH-1:0] w_lb1;
   logic [NN_WIDTH-1:0] w_col_new [3];
   logic [NH_VECTOR_WIDTH-1:0] w_vec;

   // Only the two most recent columns are kept; the third is the incoming one.
   logic [NN_WIDTH-1:0] r_win [3][2];

   assign s_ready       = !m_valid || m_ready;
   assign w_accept      = s_valid && s_ready;
   assign w_col_end     = (r_col == c_col_max);
   assign w_row_end     = (r_row == c_row_max);
   assign w_col_aligned = (r_col >= CW'(2)) && (r_cstep == '0);
   assign w_emit        = w_accept && (r_phase == PH_EMIT) && w_col_aligned;
   assign w_last        = (r_col == c_last_col) && (r_row == c_last_row);
   assign w_rstep_next  = (r_rstep == c_step_max) ? '0 : r_rstep + SW'(1);

   pool_line_buffer #(
      .DEPTH (MAP_W),
      .WIDTH (NN_WIDTH),
      .AW    (CW)
   ) u_lb0 (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (s_data),
      .o_rdata (w_lb0)
   );

   pool_line_buffer #(
      .DEPTH (MAP_W),
      .WIDTH (NN_WIDTH),
      .AW    (CW)
   ) u_lb1 (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_lb0),
      .o_rdata (w_lb1)
   );

   always_comb begin
      w_col_new[0] = w_lb1;
      w_col_new[1] = w_lb0;
      w_col_new[2] = s_data;
      w_vec        = '0;
      for (int r = 0; r < 3; r++) begin
         w_vec[NN_WIDTH*(r*3+0) +: NN_WIDTH] = r_win[r][0];
         w_vec[NN_WIDTH*(r*3+1) +: NN_WIDTH] = r_win[r][1];
         w_vec[NN_WIDTH*(r*3+2) +: NN_WIDTH] = w_col_new[r];
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= w_col_new[r];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_cstep <= '0;
         r_rstep <= '0;
         r_phase <= PH_FILL;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
      end else begin
         if (w_accept) begin
            if (w_col_end) begin
               r_col   <= '0;
               r_cstep <= '0;
               if (w_row_end) begin
                  r_row   <= '0;
                  r_rstep <= '0;
                  r_phase <= PH_FILL;
               end else begin
                  r_row <= r_row + RW'(1);
                  // Row phase tracks the row about to start, not the one ending.
                  case (r_phase)
                     PH_FILL: begin
                        r_phase <= (r_row == RW'(1)) ? PH_EMIT : PH_FILL;
                     end
                     PH_EMIT, PH_SKIP: begin
                        r_rstep <= w_rstep_next;
                        r_phase <= (w_rstep_next == '0) ? PH_EMIT : PH_SKIP;
                     end
                     default: r_phase <= PH_FILL;
                  endcase
               end
            end else begin
               r_col <= r_col + CW'(1);
               if (r_col >= CW'(2)) begin
                  r_cstep <= (r_cstep == c_step_max) ? '0 : r_cstep + SW'(1);
               end
            end
         end

         if (w_emit) begin
            m_valid <= 1'b1;
            m_data  <= w_vec;
            m_last  <= w_last;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pool_window_gen.sv
// ============================================================================
// tb_pool_window_gen : directed self-checking bench for pool_window_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pool_window_gen;
   import pool_window_gen_pkg::*;

   localparam int W   = 13;
   localparam int H   = 13;
   localparam int S   = 2;
   localparam int NWC = (W - 3) / S + 1;
   localparam int NWR = (H - 3) / S + 1;
   localparam int NWIN = NWC * NWR;
   localparam int NPIX = W * H;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       s_valid;
   logic                       s_ready;
   logic [NN_WIDTH-1:0]        s_data;
   logic                       m_valid;
   logic                       m_ready;
   logic [NH_VECTOR_WIDTH-1:0] m_data;
   logic                       m_last;

   int  checks   = 0;
   int  failures = 0;
   bit  rnd      = 1'b0;
   logic [NH_VECTOR_WIDTH:0] cap_q[$];

   pool_window_gen #(.MAP_W(W), .MAP_H(H), .STRIDE(S)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) cap_q.push_back({m_last, m_data});
   end

   task automatic check_eq(input string tag, input logic [NH_VECTOR_WIDTH-1:0] got,
                           input logic [NH_VECTOR_WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [NH_VECTOR_WIDTH-1:0] win_exp(input int R, input int C);
      logic [NH_VECTOR_WIDTH-1:0] v;
      v = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            v[NN_WIDTH*(r*3+c) +: NN_WIDTH] = NN_WIDTH'((R - 2 + r) * W + (C - 2 + c));
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push(input int d);
      bit acc;
      acc     = 1'b0;
      s_valid = 1'b1;
      s_data  = NN_WIDTH'(d);
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = s_ready;
         tick();
      end
      s_valid = 1'b0;
      check_eq("push_accept", acc, 1);
   endtask

   task automatic send_frame(input bit gaps);
      for (int n = 0; n < NPIX; n++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         push(n);
      end
   endtask

   task automatic drain();
      s_valid = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (!m_valid) break;
         tick();
      end
      check_eq("drain_idle", m_valid, 0);
      rnd     = 1'b0;
      m_ready = 1'b1;
      tick();
   endtask

   task automatic verify_frames(input string tag, input int nf);
      int n, idx;
      n = cap_q.size();
      check_eq({tag, "_count"}, n, NWIN * nf);
      for (int i = 0; i < n && i < NWIN * nf; i++) begin
         idx = i % NWIN;
         check_eq({tag, "_data"}, cap_q[i][NH_VECTOR_WIDTH-1:0],
                  win_exp(2 + S * (idx / NWC), 2 + S * (idx % NWC)));
         check_eq({tag, "_last"}, cap_q[i][NH_VECTOR_WIDTH], (idx == NWIN - 1));
      end
      cap_q.delete();
   endtask

   initial begin
      bit any_valid;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_last",  m_last,  0);
      check_eq("rst_m_data",  m_data,  0);
      check_eq("rst_s_ready", s_ready, 1);
      reset = 1'b0;
      tick();

      // Gap-free frame with spot checks on latency and the idle rows.
      any_valid = 1'b0;
      for (int n = 0; n < NPIX; n++) begin
         push(n);
         if (n < 28 || (n >= 40 && n < 52)) any_valid |= m_valid;
         if (n == 28) begin
            check_eq("first_valid", m_valid, 1);
            check_eq("first_data",  m_data,  win_exp(2, 2));
         end
         if (n == 30) check_eq("second_data", m_data, win_exp(2, 4));
      end
      check_eq("idle_rows", any_valid, 0);
      drain();
      verify_frames("full", 1);

      // Backpressure right after the first window.
      for (int n = 0; n <= 28; n++) push(n);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = NN_WIDTH'(29);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("bp_s_ready", s_ready, 0);
         check_eq("bp_m_valid", m_valid, 1);
         check_eq("bp_m_data",  m_data,  win_exp(2, 2));
      end
      tick();
      m_ready = 1'b1;
      for (int n = 29; n < NPIX; n++) push(n);
      drain();
      verify_frames("bp", 1);

      // Random valid/ready gaps.
      rnd = 1'b1;
      send_frame(1'b1);
      drain();
      verify_frames("rand", 1);

      // Back-to-back frames.
      send_frame(1'b0);
      send_frame(1'b0);
      drain();
      verify_frames("b2b", 2);

      // Reset in the middle of a frame.
      for (int n = 0; n < 50; n++) push(n);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_m_valid", m_valid, 0);
      check_eq("mid_rst_m_last",  m_last,  0);
      check_eq("mid_rst_m_data",  m_data,  0);
      check_eq("mid_rst_s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cap_q.delete();
      tick();
      for (int n = 0; n < NPIX; n++) begin
         push(n);
         if (n == 27) check_eq("post_rst_no_win", m_valid, 0);
         if (n == 28) begin
            check_eq("post_rst_valid", m_valid, 1);
            check_eq("post_rst_data",  m_data,  win_exp(2, 2));
         end
      end
      drain();
      verify_frames("post_rst", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
